tm1637_frame_engine: RTL and testbench

//  Native TM1637 two-wire protocol engine: replaces ROM-sequenced SPI-mode transfers with a hardware frame sequencer.
//  On an update request it sends three frames: data command, address plus NUM_DIGITS segment bytes, display-control command.

---
 rtl/tm1637_frame_engine_pkg.sv | 27 ++
 rtl/tm1637_frame_engine_phase_tick.sv | 31 +++
 rtl/tm1637_frame_engine.sv | 188 ++++++++++++++++++
 tb/tb_tm1637_frame_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1637_frame_engine_pkg.sv
// Shared constants, FSM encoding and command-byte helper for the TM1637 frame engine.
package tm1637_frame_engine_pkg;

    localparam logic [7:0] CMD_DATA        = 8'h40;  // write data, auto-increment address
    localparam logic [7:0] CMD_ADDR        = 8'hC0;  // address 0
    localparam logic [7:0] CMD_DISP        = 8'h80;  // display control
    localparam logic [7:0] DISP_ON_BIT     = 8'h08;
    localparam int         PHASES_PER_BYTE = 18;     // 8 bits x 2 + ACK x 2

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_BIT_LO,
        S_BIT_HI,
        S_ACK_LO,
        S_ACK_HI,
        S_STOP_A,
        S_STOP_B,
        S_STOP_C
    } state_e;

    // Display-control byte: on bit plus 3-bit pulse-width level.
    function automatic logic [7:0] disp_cmd(input logic on, input logic [2:0] bri);
        return CMD_DISP | (on ? DISP_ON_BIT : 8'h00) | {5'd0, bri};
    endfunction

endpackage

// File: rtl/tm1637_frame_engine_phase_tick.sv
// Phase pacing: down-counter that emits a one-cycle tick every CLK_DIV cycles.
// A synchronous reload restarts the count so the first phase after an accept is full length.
module tm1637_phase_tick #(
    parameter int CLK_DIV = 250
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reload_i,
    output logic tick_o
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count down, reload on request or when the current phase ends.
    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (reload_i || cnt_q == '0) cnt_d = LOAD;
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= LOAD;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/tm1637_frame_engine.sv
// TM1637 two-wire frame sequencer: sends data-command, address+segments and
// display-control frames with START/STOP and ACK checking on each update.
module tm1637_frame_engine
    import tm1637_frame_engine_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 250,
    parameter int ACK_CHECK  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    update_i,
    input  logic [8*NUM_DIGITS-1:0] seg_data_i,
    input  logic [2:0]              brightness_i,
    input  logic                    display_on_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ack_err_o,
    output logic                    tm1637_clk_o,
    output logic                    tm1637_dio_low_o,
    input  logic                    tm1637_dio_in_i
);

    state_e                  state_q, state_d;
    logic [2:0]              bit_q, bit_d;
    logic [2:0]              byte_q, byte_d;
    logic [1:0]              frame_q, frame_d;
    logic [7:0]              sh_q, sh_d;
    logic [8*NUM_DIGITS-1:0] seg_q;
    logic [2:0]              bri_q;
    logic                    on_q;
    logic                    pend_q, busy_q, done_q, aerr_q;
    logic [1:0]              sync_q;

    logic       tick, accept, last_byte, fin;
    logic [2:0] nxt_idx;
    logic [7:0] nxt_byte;
    logic [63:0] seg_ext;

    assign accept    = (state_q == S_IDLE) && (update_i || pend_q);
    assign last_byte = (frame_q != 2'd1) || (byte_q == 3'(NUM_DIGITS));
    assign fin       = tick && (state_q == S_STOP_C) && (frame_q == 2'd2);
    assign seg_ext   = 64'(seg_q);

    tm1637_phase_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .reload_i (accept),
        .tick_o   (tick)
    );

    // Byte to load next: first byte of a frame from START, else the following one.
    always_comb begin
        nxt_idx  = (state_q == S_START) ? 3'd0 : byte_q + 3'd1;
        case (frame_q)
            2'd1:    nxt_byte = (nxt_idx == 3'd0) ? CMD_ADDR
                                                  : seg_ext[{nxt_idx - 3'd1, 3'b000} +: 8];
            2'd2:    nxt_byte = disp_cmd(on_q, bri_q);
            default: nxt_byte = CMD_DATA;
        endcase
    end

    // FSM state and frame counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            frame_q <= 2'd0;
            sh_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            sh_q    <= sh_d;
        end
    end

    // Next state: advance one phase per tick; bytes go out LSB first.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        sh_d    = sh_q;
        if (accept) begin
            state_d = S_START;
            frame_d = 2'd0;
        end else if (tick) begin
            case (state_q)
                S_START: begin
                    state_d = S_BIT_LO;
                    sh_d    = nxt_byte;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                end
                S_BIT_LO: state_d = S_BIT_HI;
                S_BIT_HI: begin
                    bit_d = bit_q + 3'd1;  // 7 wraps to 0, ready for the next byte
                    if (bit_q == 3'd7) begin
                        state_d = S_ACK_LO;
                    end else begin
                        state_d = S_BIT_LO;
                        sh_d    = {1'b0, sh_q[7:1]};
                    end
                end
                S_ACK_LO: state_d = S_ACK_HI;
                S_ACK_HI: begin
                    if (last_byte) begin
                        state_d = S_STOP_A;
                    end else begin
                        state_d = S_BIT_LO;
                        byte_d  = byte_q + 3'd1;
                        sh_d    = nxt_byte;
                    end
                end
                S_STOP_A: state_d = S_STOP_B;
                S_STOP_B: state_d = S_STOP_C;
                S_STOP_C: begin
                    if (frame_q == 2'd2) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_START;
                        frame_d = frame_q + 2'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pin levels are a pure decode of state and current bit, so they move only on phase edges.
    always_comb begin
        tm1637_clk_o     = 1'b1;
        tm1637_dio_low_o = 1'b0;
        case (state_q)
            S_START:  tm1637_dio_low_o = 1'b1;
            S_BIT_LO: begin
                tm1637_clk_o     = 1'b0;
                tm1637_dio_low_o = ~sh_q[0];
            end
            S_BIT_HI: tm1637_dio_low_o = ~sh_q[0];
            S_ACK_LO: tm1637_clk_o = 1'b0;
            S_STOP_A: begin
                tm1637_clk_o     = 1'b0;
                tm1637_dio_low_o = 1'b1;
            end
            S_STOP_B: tm1637_dio_low_o = 1'b1;
            default:  ;
        endcase
    end

    // Shadow inputs, status flags, pending request and DIO synchroniser.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_q  <= '0;
            bri_q  <= 3'd0;
            on_q   <= 1'b0;
            pend_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            aerr_q <= 1'b0;
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], tm1637_dio_in_i};
            done_q <= fin;
            if (accept) begin
                seg_q  <= seg_data_i;
                bri_q  <= brightness_i;
                on_q   <= display_on_i;
                busy_q <= 1'b1;
                aerr_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                if (fin) busy_q <= 1'b0;
                if (update_i) pend_q <= 1'b1;  // only reachable while not idle
                // A released (high) line at the end of the ACK clock means no slave ack.
                if (tick && state_q == S_ACK_HI && ACK_CHECK != 0 && sync_q[1]) aerr_q <= 1'b1;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ack_err_o = aerr_q;

endmodule

// File: tb/tb_tm1637_frame_engine.sv
// Directed bench for tm1637_frame_engine with a simple TM1637 slave model.
module tb_tm1637_frame_engine;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [2:0]  upd     = 3'b000;
    logic [31:0] seg     = 32'h4F5B063F;  // digit0 in the low byte
    logic [2:0]  bri     = 3'd7;
    logic        on      = 1'b1;
    logic        bfm_clr = 1'b1;
    logic        wh_en   = 1'b0;
    logic [7:0]  wh_byte = 8'h06;
    logic [2:0]  busy_w, done_w, aerr_w;
    logic        clk2, dlo2;
    int          cyc = 0;
    int          acc, lat, seen;
    int          n_cmp = 0, n_err = 0;

    logic [7:0] exp1 [7] = '{8'h40, 8'hC0, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h8F};
    logic [7:0] exp3 [7] = '{8'h40, 8'hC0, 8'h6D, 8'h7F, 8'h07, 8'h66, 8'h8F};
    logic [7:0] exp5 [4] = '{8'h40, 8'hC0, 8'h3F, 8'h8F};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int N = (g == 0) ? 4 : 1;
        logic       bclk, bdlo, sda;
        logic       pull, pscl, psda;
        logic [7:0] sh, lastb;
        logic [7:0] lg [32];
        int         bc, nlog;

        assign sda = ~(bdlo | pull);

        tm1637_frame_engine #(.NUM_DIGITS(N), .CLK_DIV(4), .ACK_CHECK(1)) dut (
            .clk_i            (clk),
            .rst_i            (rst),
            .update_i         (upd[g]),
            .seg_data_i       (seg[8*N-1:0]),
            .brightness_i     (bri),
            .display_on_i     (on),
            .busy_o           (busy_w[g]),
            .done_o           (done_w[g]),
            .ack_err_o        (aerr_w[g]),
            .tm1637_clk_o     (bclk),
            .tm1637_dio_low_o (bdlo),
            .tm1637_dio_in_i  (sda)
        );

        // Slave: START/STOP restart the bit count, bits taken on CLK rise, ACK driven for the 9th clock.
        always @(negedge clk) begin
            if (bfm_clr) begin
                pull <= 1'b0; pscl <= 1'b1; psda <= 1'b1; bc <= 0; nlog <= 0;
            end else begin
                pscl <= bclk;
                psda <= sda;
                if (pscl && bclk && psda && !sda)      bc <= 0;
                else if (pscl && bclk && !psda && sda) bc <= 0;
                else if (!pscl && bclk) begin
                    if (bc < 8) begin
                        sh[bc] <= sda;
                        if (bc == 7) begin
                            lastb <= {sda, sh[6:0]};
                            if (nlog < 32) lg[nlog] <= {sda, sh[6:0]};
                            nlog <= nlog + 1;
                        end
                        bc <= bc + 1;
                    end else if (bc == 8) begin
                        bc <= 9;
                    end
                end else if (pscl && !bclk) begin
                    if (bc == 8) pull <= !(wh_en && lastb == wh_byte);
                    else if (bc == 9) begin
                        pull <= 1'b0;
                        bc   <= 0;
                    end
                end
            end
        end
    end

    tm1637_frame_engine #(.NUM_DIGITS(1), .CLK_DIV(4), .ACK_CHECK(0)) dut_nack (
        .clk_i            (clk),
        .rst_i            (rst),
        .update_i         (upd[2]),
        .seg_data_i       (seg[7:0]),
        .brightness_i     (bri),
        .display_on_i     (on),
        .busy_o           (busy_w[2]),
        .done_o           (done_w[2]),
        .ack_err_o        (aerr_w[2]),
        .tm1637_clk_o     (clk2),
        .tm1637_dio_low_o (dlo2),
        .tm1637_dio_in_i  (1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int g);
        @(negedge clk); upd[g] = 1'b1;
        @(negedge clk); upd[g] = 1'b0;
    endtask

    // Leaves the bench at the negedge of cycle 1 after the accept edge.
    task automatic kick(input int g);
        pulse(g);
        acc = cyc;
    endtask

    task automatic step_to(input int k);
        while (cyc - acc + 1 < k) @(negedge clk);
    endtask

    task automatic wait_done(input int g);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done_w[g]) begin
                lat = cyc - acc + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic clr_bfm();
        bfm_clr = 1'b1;
        @(negedge clk); @(negedge clk);
        bfm_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy_w), 0);
        chk("rst_done",  32'(done_w), 0);
        chk("rst_ackerr", 32'(aerr_w), 0);
        chk("rst_clk",   32'({clk2, u[1].bclk, u[0].bclk}), 32'h7);
        chk("rst_dio",   32'({dlo2, u[1].bdlo, u[0].bdlo}), 0);
        rst = 1'b0;
        bfm_clr = 1'b0;
        @(negedge clk);

        // 1: nominal N=4 update
        kick(0);
        chk("t1_busy_c1", 32'(busy_w[0]), 1);
        chk("t1_start_clk", 32'(u[0].bclk), 1);
        chk("t1_start_dio", 32'(u[0].bdlo), 1);
        wait_done(0);
        chk("t1_done_cycle", lat, 553);
        chk("t1_busy_at_done", 32'(busy_w[0]), 0);
        chk("t1_nbytes", u[0].nlog, 7);
        for (int i = 0; i < 7; i++) chk($sformatf("t1_byte%0d", i), 32'(u[0].lg[i]), 32'(exp1[i]));
        chk("t1_ackerr", 32'(aerr_w[0]), 0);

        // 2: slave withholds ACK on 0x06 (ACK_HI ends in cycle 308)
        clr_bfm();
        wh_en = 1'b1;
        kick(0);
        step_to(308);
        chk("t2_ackerr_before", 32'(aerr_w[0]), 0);
        step_to(309);
        chk("t2_ackerr_after", 32'(aerr_w[0]), 1);
        wait_done(0);
        chk("t2_done_cycle", lat, 553);
        chk("t2_nbytes", u[0].nlog, 7);
        chk("t2_byte6", 32'(u[0].lg[6]), 32'h8F);
        chk("t2_ackerr_end", 32'(aerr_w[0]), 1);
        wh_en = 1'b0;

        // 5a: display off, level 3; also clears ack_err on accept
        clr_bfm();
        on = 1'b0; bri = 3'd3;
        kick(0);
        chk("t5_ackerr_cleared", 32'(aerr_w[0]), 0);
        wait_done(0);
        chk("t5_done_cycle", lat, 553);
        chk("t5_byte2", 32'(u[0].lg[2]), 32'h3F);
        chk("t5_f3", 32'(u[0].lg[6]), 32'h83);
        on = 1'b1; bri = 3'd7;

        // 3: two requests while busy merge into one restart carrying the latest seg
        clr_bfm();
        kick(0);
        step_to(100);
        seg = 32'h11223344;
        pulse(0);
        step_to(200);
        seg = 32'h66077F6D;
        pulse(0);
        wait_done(0);
        chk("t3_done1_cycle", lat, 553);
        chk("t3_busy_at_done", 32'(busy_w[0]), 0);
        @(negedge clk);
        chk("t3_restart_busy", 32'(busy_w[0]), 1);
        acc = cyc;
        wait_done(0);
        chk("t3_done2_cycle", lat, 553);
        chk("t3_run1_seg0", 32'(u[0].lg[2]), 32'h3F);
        for (int i = 0; i < 7; i++) chk($sformatf("t3_byte%0d", i), 32'(u[0].lg[7+i]), 32'(exp3[i]));
        repeat (20) @(negedge clk);
        chk("t3_no_third_run", 32'(busy_w[0]), 0);
        chk("t3_nbytes", u[0].nlog, 14);
        seg = 32'h4F5B063F;

        // 4: reset during phase 60 (bit 0 of 0x06: clk low, dio low)
        clr_bfm();
        kick(0);
        step_to(238);
        chk("t4_pre_clk", 32'(u[0].bclk), 0);
        chk("t4_pre_dio", 32'(u[0].bdlo), 1);
        rst = 1'b1;
        #1;
        chk("t4_rst_clk", 32'(u[0].bclk), 1);
        chk("t4_rst_dio", 32'(u[0].bdlo), 0);
        chk("t4_rst_busy", 32'(busy_w[0]), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) seen++;
        end
        chk("t4_no_done_after_rst", seen, 0);
        clr_bfm();
        kick(0);
        wait_done(0);
        chk("t4_rerun_cycle", lat, 553);
        chk("t4_rerun_nbytes", u[0].nlog, 7);
        for (int i = 0; i < 7; i++) chk($sformatf("t4_byte%0d", i), 32'(u[0].lg[i]), 32'(exp1[i]));

        // 5b: N=1 -> 84 phases
        clr_bfm();
        kick(1);
        wait_done(1);
        chk("t5n1_done_cycle", lat, 337);
        chk("t5n1_nbytes", u[1].nlog, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t5n1_byte%0d", i), 32'(u[1].lg[i]), 32'(exp5[i]));
        chk("t5n1_ackerr", 32'(aerr_w[1]), 0);

        // 6: ACK checking disabled, line never acked
        kick(2);
        chk("t6_busy_c1", 32'(busy_w[2]), 1);
        wait_done(2);
        chk("t6_done_cycle", lat, 337);
        chk("t6_ackerr", 32'(aerr_w[2]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
